gerador_permutacao: RTL and testbench

- Builds a random ordering of the game's N items (Fisher-Yates shuffle) from a 16-bit random word supplied by the LFSR randomizer.
- Sits directly upstream of the index register in the data path: its `perm` output feeds the 8-bit index register, and its `ready` flag tells the control unit when to pulse the register load.
- Performs one swap per clock cycle and holds the result stable until the next start.

---
 rtl/gerador_permutacao.sv | 114 +++++++++++
 tb/tb_gerador_permutacao.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gerador_permutacao.sv
// Fisher-Yates shuffle of N indices driven by a captured random seed.
// Optional GERADOR_PERM_CHECK_EN adds a registered distinctness flag perm_ok.
module gerador_permutacao #(
  parameter int N      = 4,
  parameter int IDX_W  = 2,
  parameter int RAND_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inicia,
  input  logic [RAND_W-1:0]    entrada,
  output logic [N*IDX_W-1:0]   perm,
  output logic                 ready,
`ifdef GERADOR_PERM_CHECK_EN
  output logic                 perm_ok,
`endif
  output logic                 ocupado
);

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] EMBARALHA = 2'd1;
  localparam logic [1:0] PRONTO    = 2'd2;

  logic [1:0]        estado;
  logic [IDX_W-1:0]  i;
  logic [IDX_W-1:0]  j;
  logic [RAND_W-1:0] seed;
  logic [RAND_W-1:0] seed_rot;
  logic [15:0]       prod;
  logic [IDX_W-1:0]  a     [N];
  logic [IDX_W-1:0]  a_nxt [N];

  // j = floor(r*(i+1)/256) is always within 0..i
  assign prod     = {8'd0, seed[7:0]} * (16'(i) + 16'd1);
  assign j        = IDX_W'(prod >> 8);
  assign seed_rot = {seed[RAND_W-4:0], seed[RAND_W-1:RAND_W-3]};

  always_comb begin
    for (int k = 0; k < N; k++)
      a_nxt[k] = a[k];
    if (estado == EMBARALHA) begin
      a_nxt[i] = a[j];
      a_nxt[j] = a[i];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_perm
    assign perm[k*IDX_W +: IDX_W] = a[k];
  end

`ifdef GERADOR_PERM_CHECK_EN
  logic uniq;

  always_comb begin
    uniq = 1'b1;
    for (int p = 0; p < N; p++)
      for (int q = p + 1; q < N; q++)
        if (a_nxt[p] == a_nxt[q])
          uniq = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      perm_ok <= 1'b0;
    else if (estado != EMBARALHA && inicia)
      perm_ok <= 1'b0;
    else if (estado == EMBARALHA && i == IDX_W'(1))
      perm_ok <= uniq;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado  <= OCIOSO;
      i       <= '0;
      seed    <= '0;
      ready   <= 1'b0;
      ocupado <= 1'b0;
      for (int k = 0; k < N; k++)
        a[k] <= IDX_W'(k);
    end else begin
      unique case (estado)
        OCIOSO, PRONTO: begin
          if (inicia) begin
            seed    <= entrada;
            i       <= IDX_W'(N - 1);
            estado  <= EMBARALHA;
            ready   <= 1'b0;
            ocupado <= 1'b1;
            for (int k = 0; k < N; k++)
              a[k] <= IDX_W'(k);
          end
        end
        EMBARALHA: begin
          for (int k = 0; k < N; k++)
            a[k] <= a_nxt[k];
          seed <= seed_rot;
          i    <= i - IDX_W'(1);
          if (i == IDX_W'(1)) begin
            estado  <= PRONTO;
            ready   <= 1'b1;
            ocupado <= 1'b0;
          end
        end
        default: begin
          estado  <= OCIOSO;
          ready   <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gerador_permutacao.sv
// Directed vectors and corner sequences for gerador_permutacao.
// Random runs compare against a shuffle model and a distinctness check.
module tb_gerador_permutacao;

  logic        clock = 1'b0;
  logic        reset;
  logic        inicia;
  logic [15:0] entrada;
  logic [7:0]  perm;
  logic        ready;
  logic        ocupado;
`ifdef GERADOR_PERM_CHECK_EN
  logic        perm_ok;
`endif

  int tests = 0;
  int fails = 0;

  gerador_permutacao dut (
    .clock   (clock),
    .reset   (reset),
    .inicia  (inicia),
    .entrada (entrada),
    .perm    (perm),
    .ready   (ready),
`ifdef GERADOR_PERM_CHECK_EN
    .perm_ok (perm_ok),
`endif
    .ocupado (ocupado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] seed;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [15:0] s);
    int a [4];
    int j, t;
    logic [15:0] sd;
    logic [7:0]  r;
    sd = s;
    for (int k = 0; k < 4; k++) a[k] = k;
    for (int i = 3; i >= 1; i--) begin
      j = (int'(sd[7:0]) * (i + 1)) >> 8;
      t = a[i]; a[i] = a[j]; a[j] = t;
      sd = {sd[12:0], sd[15:13]};
    end
    r = '0;
    for (int k = 0; k < 4; k++) r = r | (8'(a[k]) << (2 * k));
    return r;
  endfunction

  task automatic start(input logic [15:0] s);
    @(negedge clock);
    entrada = s;
    inicia  = 1'b1;
    @(negedge clock);
    inicia  = 1'b0;
  endtask

  task automatic run(input logic [15:0] s, input logic [7:0] e,
                     input string nm);
    int lat;
    start(s);
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (!ready && !ocupado)
        chk({nm, " ocupado"}, 0, 1);
    end while (!ready && lat < 10);
    chk({nm, " latency"}, lat, 3);
    chk({nm, " perm"}, perm, e);
`ifdef GERADOR_PERM_CHECK_EN
    chk({nm, " perm_ok"}, perm_ok, 1);
`endif
  endtask

  initial begin
    vecs[0] = '{16'h0000, 8'h39};
    vecs[1] = '{16'hFFFF, 8'hE4};
    vecs[2] = '{16'h0080, 8'h8D};
    vecs[3] = '{16'h00C0, 8'hC9};
    vecs[4] = '{16'h0040, 8'h4B};
    vecs[5] = '{16'hE01F, 8'h27};

    reset = 1'b1; inicia = 1'b0; entrada = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("reset perm", perm, 8'hE4);
    chk("reset ready", ready, 0);
    chk("reset ocupado", ocupado, 0);

    for (int v = 0; v < 6; v++)
      run(vecs[v].seed, vecs[v].exp, $sformatf("vec%0d", v));

    // result holds while inicia stays low
    repeat (3) @(posedge clock);
    #1;
    chk("hold perm", perm, 8'h27);
    chk("hold ready", ready, 1);

    // second start during shuffle is ignored
    @(negedge clock);
    entrada = 16'h0000; inicia = 1'b1;
    @(negedge clock);
    entrada = 16'hFFFF;
    @(negedge clock);
    inicia = 1'b0;
    @(posedge clock); #1;
    chk("ignore ready e2", ready, 0);
    chk("ignore ocupado e2", ocupado, 1);
    @(posedge clock); #1;
    chk("ignore ready e3", ready, 1);
    chk("ignore perm", perm, 8'h39);

    // inicia held high: ready lasts one cycle
    @(negedge clock);
    entrada = 16'hFFFF; inicia = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("held ready e3", ready, 1);
    chk("held perm e3", perm, 8'hE4);
    @(posedge clock); #1;
    chk("held ready e4", ready, 0);
    chk("held ocupado e4", ocupado, 1);
    @(negedge clock);
    inicia = 1'b0;
    repeat (4) @(negedge clock);

    // asynchronous reset mid-shuffle
    start(16'h0000);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("midrst perm", perm, 8'hE4);
    chk("midrst ready", ready, 0);
    chk("midrst ocupado", ocupado, 0);
    @(negedge clock);
    reset = 1'b0;
    run(16'h0000, 8'h39, "after_rst");

    for (int n = 0; n < 1000; n++) begin
      logic [15:0] s;
      logic [1:0]  f [4];
      int dup;
      s = 16'($urandom);
      run(s, model(s), "rand");
      for (int k = 0; k < 4; k++) f[k] = perm[2*k +: 2];
      dup = 0;
      for (int p = 0; p < 4; p++)
        for (int q = p + 1; q < 4; q++)
          if (f[p] == f[q]) dup = 1;
      chk("rand distinct", dup, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
